s2mm_write_sequencer: RTL and testbench

Sequences the stream-to-memory write path of the vibrometer capture chain. It accepts samples from an AXI4-Stream source and issues one single-beat AXI4 write per sample to the address supplied by the buffer sync manager. It drives the manager's per-sample accept pulse (`SM_reading`) and per-sample completion pulse (`SM_writing`), so buffer rotation tracks data actually committed to memory.

---
 rtl/s2mm_write_sequencer.sv | 150 +++++++++++++++
 tb/tb_s2mm_write_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_write_sequencer.sv
// Stream-to-memory write sequencer: one single-beat AXI4 write per accepted AXI4-Stream sample.
// Optional build macro S2MM_ERROR_COUNT_EN enables the saturating non-OKAY response counter.
module s2mm_write_sequencer #(
  parameter int MM_ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      SYS_aclk,
  input  logic                      SYS_aresetn,
  input  logic                      SM_enable,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [MM_ADDR_WIDTH-1:0]  SM_write_buffer,
  output logic                      SM_reading,
  output logic                      SM_writing,
  output logic [MM_ADDR_WIDTH-1:0]  M_AXI_awaddr,
  output logic [7:0]                M_AXI_awlen,
  output logic [2:0]                M_AXI_awsize,
  output logic [1:0]                M_AXI_awburst,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wlast,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  output logic [15:0]               SM_error_count
);

  localparam int         STRB_W  = DATA_WIDTH / 8;
  localparam logic [2:0] AWSIZE  = 3'($clog2(STRB_W));
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state;
  logic                       run_p0;
  logic [3:0]                 outstanding;
  logic                       aw_done;
  logic                       w_done;
  logic                       awvalid_p1;
  logic                       wvalid_p1;
  logic [MM_ADDR_WIDTH-1:0]   awaddr_p1;
  logic [DATA_WIDTH-1:0]      wdata_p1;
  logic [15:0]                err_count;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic issue_done;
  logic cnt_inc;
  logic cnt_dec;

`ifdef S2MM_ERROR_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // run_p0 is a registered "out of reset" flag so tready/bready read 0 during reset.
  assign S_AXIS_tready = run_p0 & (state == IDLE) & SM_enable & (outstanding < MAX_OUT);
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;
  assign aw_hs         = awvalid_p1 & M_AXI_awready;
  assign w_hs          = wvalid_p1 & M_AXI_wready;
  assign b_hs          = M_AXI_bvalid & run_p0;
  assign issue_done    = (state == ISSUE) & (aw_done | aw_hs) & (w_done | w_hs);
  assign cnt_inc       = issue_done;
  assign cnt_dec       = b_hs & (outstanding != 4'd0);

  assign SM_reading    = accept;
  assign SM_writing    = b_hs;
  assign M_AXI_bready  = run_p0;
  assign M_AXI_awaddr  = awaddr_p1;
  assign M_AXI_awvalid = awvalid_p1;
  assign M_AXI_wdata   = wdata_p1;
  assign M_AXI_wvalid  = wvalid_p1;
  assign M_AXI_awlen   = 8'd0;
  assign M_AXI_awsize  = AWSIZE;
  assign M_AXI_awburst = 2'b01;
  assign M_AXI_wstrb   = {STRB_W{1'b1}};
  assign M_AXI_wlast   = 1'b1;
  assign SM_error_count = err_count;

`ifndef S2MM_ERROR_COUNT_EN
  logic unused_bresp;
  assign unused_bresp = ^M_AXI_bresp;
  assign err_count    = 16'd0;
`endif

  always_ff @(posedge SYS_aclk) begin
    if (!SYS_aresetn) begin
      state       <= IDLE;
      run_p0      <= 1'b0;
      outstanding <= 4'd0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      awvalid_p1  <= 1'b0;
      wvalid_p1   <= 1'b0;
      awaddr_p1   <= '0;
      wdata_p1    <= '0;
`ifdef S2MM_ERROR_COUNT_EN
      err_count   <= 16'd0;
`endif
    end else begin
      run_p0 <= 1'b1;
      // p0 -> p1: sample captured on accept, AW/W issued from p1 registers
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ISSUE;
            awaddr_p1  <= SM_write_buffer;
            wdata_p1   <= S_AXIS_tdata;
            awvalid_p1 <= 1'b1;
            wvalid_p1  <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            awvalid_p1 <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            wvalid_p1 <= 1'b0;
            w_done    <= 1'b1;
          end
          if (issue_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      case ({cnt_inc, cnt_dec})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

`ifdef S2MM_ERROR_COUNT_EN
      if (b_hs && (M_AXI_bresp != 2'b00)) err_count <= sat_inc16(err_count);
`endif
    end
  end

endmodule

// File: tb/tb_s2mm_write_sequencer.sv
// Directed self-checking bench for s2mm_write_sequencer (default parameters).
module tb_s2mm_write_sequencer;

  logic        SYS_aclk;
  logic        SYS_aresetn;
  logic        SM_enable;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] SM_write_buffer;
  logic        SM_reading;
  logic        SM_writing;
  logic [31:0] M_AXI_awaddr;
  logic [7:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize;
  logic [1:0]  M_AXI_awburst;
  logic        M_AXI_awvalid;
  logic        M_AXI_awready;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast;
  logic        M_AXI_wvalid;
  logic        M_AXI_wready;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_bvalid;
  logic        M_AXI_bready;
  logic [15:0] SM_error_count;

  int checks = 0;
  int fails  = 0;

  s2mm_write_sequencer #(.MM_ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .SYS_aclk(SYS_aclk), .SYS_aresetn(SYS_aresetn), .SM_enable(SM_enable),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .SM_write_buffer(SM_write_buffer), .SM_reading(SM_reading), .SM_writing(SM_writing),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awsize(M_AXI_awsize),
    .M_AXI_awburst(M_AXI_awburst), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .SM_error_count(SM_error_count)
  );

  initial SYS_aclk = 1'b0;
  always #5 SYS_aclk = ~SYS_aclk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge SYS_aclk);
    #1;
  endtask

  task automatic test_reset();
    SYS_aresetn = 1'b0; SM_enable = 1'b1; S_AXIS_tvalid = 1'b1; M_AXI_bvalid = 1'b1;
    M_AXI_bresp = 2'b10; M_AXI_awready = 1'b1; M_AXI_wready = 1'b1;
    S_AXIS_tdata = 32'hDEAD_BEEF; SM_write_buffer = 32'hCAFE_0000;
    repeat (2) tick();
    #1;
    checks++; if (S_AXIS_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %b exp 0", S_AXIS_tready); end
    checks++; if (SM_reading !== 1'b0) begin fails++; $display("FAIL reset_reading got %b exp 0", SM_reading); end
    checks++; if (SM_writing !== 1'b0) begin fails++; $display("FAIL reset_writing got %b exp 0", SM_writing); end
    checks++; if (M_AXI_awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid got %b exp 0", M_AXI_awvalid); end
    checks++; if (M_AXI_wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid got %b exp 0", M_AXI_wvalid); end
    checks++; if (M_AXI_bready !== 1'b0) begin fails++; $display("FAIL reset_bready got %b exp 0", M_AXI_bready); end
    checks++; if (M_AXI_awaddr !== 32'h0) begin fails++; $display("FAIL reset_awaddr got %h exp 0", M_AXI_awaddr); end
    checks++; if (M_AXI_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", M_AXI_wdata); end
    checks++; if (SM_error_count !== 16'h0) begin fails++; $display("FAIL reset_errcnt got %h exp 0", SM_error_count); end
    checks++; if (M_AXI_awlen !== 8'd0) begin fails++; $display("FAIL awlen got %h exp 0", M_AXI_awlen); end
    checks++; if (M_AXI_awsize !== 3'd2) begin fails++; $display("FAIL awsize got %h exp 2", M_AXI_awsize); end
    checks++; if (M_AXI_awburst !== 2'b01) begin fails++; $display("FAIL awburst got %b exp 01", M_AXI_awburst); end
    checks++; if (M_AXI_wstrb !== 4'hF) begin fails++; $display("FAIL wstrb got %h exp f", M_AXI_wstrb); end
    checks++; if (M_AXI_wlast !== 1'b1) begin fails++; $display("FAIL wlast got %b exp 1", M_AXI_wlast); end
    S_AXIS_tvalid = 1'b0; M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00; SYS_aresetn = 1'b1;
    tick();
    #1;
    checks++; if (M_AXI_bready !== 1'b1) begin fails++; $display("FAIL bready_after_reset got %b exp 1", M_AXI_bready); end
    tick();
  endtask

  task automatic test_single();
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; SM_enable = 1'b1;
    S_AXIS_tdata = 32'hA5A5_0001; SM_write_buffer = 32'h1000_0000; S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL single_tready got %b exp 1", S_AXIS_tready); end
    checks++; if (SM_reading !== 1'b1) begin fails++; $display("FAIL single_reading got %b exp 1", SM_reading); end
    tick();
    S_AXIS_tvalid = 1'b0; S_AXIS_tdata = 32'h0; SM_write_buffer = 32'h2000_0000;
    #1;
    checks++; if (M_AXI_awvalid !== 1'b1) begin fails++; $display("FAIL single_awvalid got %b exp 1", M_AXI_awvalid); end
    checks++; if (M_AXI_wvalid !== 1'b1) begin fails++; $display("FAIL single_wvalid got %b exp 1", M_AXI_wvalid); end
    checks++; if (M_AXI_awaddr !== 32'h1000_0000) begin fails++; $display("FAIL single_awaddr got %h exp 10000000", M_AXI_awaddr); end
    checks++; if (M_AXI_wdata !== 32'hA5A5_0001) begin fails++; $display("FAIL single_wdata got %h exp a5a50001", M_AXI_wdata); end
    checks++; if (S_AXIS_tready !== 1'b0) begin fails++; $display("FAIL single_tready_issue got %b exp 0", S_AXIS_tready); end
    tick();
    M_AXI_bvalid = 1'b1; M_AXI_bresp = 2'b00;
    #1;
    checks++; if (M_AXI_awvalid !== 1'b0) begin fails++; $display("FAIL single_awvalid_drop got %b exp 0", M_AXI_awvalid); end
    checks++; if (M_AXI_wvalid !== 1'b0) begin fails++; $display("FAIL single_wvalid_drop got %b exp 0", M_AXI_wvalid); end
    checks++; if (S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL single_idle_t2 got %b exp 1", S_AXIS_tready); end
    checks++; if (dut.outstanding !== 4'd1) begin fails++; $display("FAIL single_outstanding got %0d exp 1", dut.outstanding); end
    checks++; if (SM_writing !== 1'b1) begin fails++; $display("FAIL single_writing got %b exp 1", SM_writing); end
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    checks++; if (SM_writing !== 1'b0) begin fails++; $display("FAIL single_writing_end got %b exp 0", SM_writing); end
    checks++; if (dut.outstanding !== 4'd0) begin fails++; $display("FAIL single_drain got %0d exp 0", dut.outstanding); end
    tick();
  endtask

  task automatic test_skewed();
    M_AXI_awready = 1'b0; M_AXI_wready = 1'b1;
    S_AXIS_tdata = 32'h0000_5A5A; SM_write_buffer = 32'h1000_0004; S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (SM_reading !== 1'b1) begin fails++; $display("FAIL skew_reading got %b exp 1", SM_reading); end
    tick();
    S_AXIS_tvalid = 1'b0;
    #1;
    checks++; if ({M_AXI_awvalid, M_AXI_wvalid} !== 2'b11) begin fails++; $display("FAIL skew_t1_valids got %b exp 11", {M_AXI_awvalid, M_AXI_wvalid}); end
    tick();
    #1;
    checks++; if ({M_AXI_awvalid, M_AXI_wvalid} !== 2'b10) begin fails++; $display("FAIL skew_t2_valids got %b exp 10", {M_AXI_awvalid, M_AXI_wvalid}); end
    checks++; if (dut.outstanding !== 4'd0) begin fails++; $display("FAIL skew_t2_outstanding got %0d exp 0", dut.outstanding); end
    tick();
    #1;
    checks++; if (M_AXI_awvalid !== 1'b1) begin fails++; $display("FAIL skew_t3_awvalid got %b exp 1", M_AXI_awvalid); end
    checks++; if (S_AXIS_tready !== 1'b0) begin fails++; $display("FAIL skew_t3_tready got %b exp 0", S_AXIS_tready); end
    tick();
    M_AXI_awready = 1'b1;
    #1;
    checks++; if (M_AXI_awvalid !== 1'b1) begin fails++; $display("FAIL skew_t4_awvalid got %b exp 1", M_AXI_awvalid); end
    checks++; if (M_AXI_awaddr !== 32'h1000_0004) begin fails++; $display("FAIL skew_t4_awaddr got %h exp 10000004", M_AXI_awaddr); end
    tick();
    M_AXI_bvalid = 1'b1;
    #1;
    checks++; if (M_AXI_awvalid !== 1'b0) begin fails++; $display("FAIL skew_t5_awvalid got %b exp 0", M_AXI_awvalid); end
    checks++; if (S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL skew_t5_idle got %b exp 1", S_AXIS_tready); end
    checks++; if (dut.outstanding !== 4'd1) begin fails++; $display("FAIL skew_t5_outstanding got %0d exp 1", dut.outstanding); end
    tick();
    M_AXI_bvalid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3;
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; SM_enable = 1'b1; M_AXI_bvalid = 1'b0;
    S_AXIS_tvalid = 1'b1;
    n1 = 0; n2 = 0; n3 = 0;
    for (int i = 0; i < 8; i++) begin
      S_AXIS_tdata = 32'(i); SM_write_buffer = 32'h3000_0000 + 32'(i * 4);
      #1;
      if (SM_reading === 1'b1) n1++;
      tick();
    end
    checks++; if (n1 !== 4) begin fails++; $display("FAIL b2b_accepts got %0d exp 4", n1); end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (SM_reading === 1'b1) n2++;
      tick();
    end
    checks++; if (n2 !== 0) begin fails++; $display("FAIL b2b_throttled_accepts got %0d exp 0", n2); end
    checks++; if (dut.outstanding !== 4'd4) begin fails++; $display("FAIL b2b_outstanding got %0d exp 4", dut.outstanding); end
    M_AXI_bvalid = 1'b1;
    #1;
    checks++; if (SM_writing !== 1'b1) begin fails++; $display("FAIL b2b_writing got %b exp 1", SM_writing); end
    checks++; if (S_AXIS_tready !== 1'b0) begin fails++; $display("FAIL b2b_tready_bcycle got %b exp 0", S_AXIS_tready); end
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    checks++; if (S_AXIS_tready !== 1'b1) begin fails++; $display("FAIL b2b_tready_return got %b exp 1", S_AXIS_tready); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) #1;
      if (SM_reading === 1'b1) n3++;
      tick();
    end
    checks++; if (n3 !== 1) begin fails++; $display("FAIL b2b_extra_accepts got %0d exp 1", n3); end
    checks++; if (dut.outstanding !== 4'd4) begin fails++; $display("FAIL b2b_refill got %0d exp 4", dut.outstanding); end
    S_AXIS_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_enable_reset();
    int acc, wr;
    M_AXI_bvalid = 1'b1;
    tick();
    M_AXI_bvalid = 1'b0;
    tick();
    checks++; if (dut.outstanding !== 4'd3) begin fails++; $display("FAIL en_start_outstanding got %0d exp 3", dut.outstanding); end
    SM_enable = 1'b0; S_AXIS_tvalid = 1'b1;
    acc = 0; wr = 0;
    for (int i = 0; i < 10; i++) begin
      M_AXI_bvalid = (i == 1 || i == 3 || i == 5);
      #1;
      if (SM_reading === 1'b1) acc++;
      if (SM_writing === 1'b1) wr++;
      tick();
    end
    M_AXI_bvalid = 1'b0;
    checks++; if (acc !== 0) begin fails++; $display("FAIL en_accepts got %0d exp 0", acc); end
    checks++; if (wr !== 3) begin fails++; $display("FAIL en_writing got %0d exp 3", wr); end
    checks++; if (dut.outstanding !== 4'd0) begin fails++; $display("FAIL en_drained got %0d exp 0", dut.outstanding); end
    S_AXIS_tvalid = 1'b0; M_AXI_bvalid = 1'b1;
    #1;
    checks++; if (SM_writing !== 1'b1) begin fails++; $display("FAIL underflow_writing got %b exp 1", SM_writing); end
    tick();
    M_AXI_bvalid = 1'b0;
    #1;
    checks++; if (dut.outstanding !== 4'd0) begin fails++; $display("FAIL underflow_count got %0d exp 0", dut.outstanding); end
    tick();
    SM_enable = 1'b1; M_AXI_awready = 1'b0; M_AXI_wready = 1'b0;
    S_AXIS_tdata = 32'h0000_1234; SM_write_buffer = 32'h4000_0000; S_AXIS_tvalid = 1'b1;
    #1;
    checks++; if (SM_reading !== 1'b1) begin fails++; $display("FAIL rst_pre_accept got %b exp 1", SM_reading); end
    tick();
    #1;
    checks++; if (M_AXI_awvalid !== 1'b1) begin fails++; $display("FAIL rst_in_issue got %b exp 1", M_AXI_awvalid); end
    SYS_aresetn = 1'b0; M_AXI_bvalid = 1'b1;
    tick();
    #1;
    checks++; if ({M_AXI_awvalid, M_AXI_wvalid} !== 2'b00) begin fails++; $display("FAIL rst_valids got %b exp 00", {M_AXI_awvalid, M_AXI_wvalid}); end
    checks++; if (M_AXI_awaddr !== 32'h0) begin fails++; $display("FAIL rst_awaddr got %h exp 0", M_AXI_awaddr); end
    checks++; if (M_AXI_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata got %h exp 0", M_AXI_wdata); end
    checks++; if ({S_AXIS_tready, SM_reading, SM_writing, M_AXI_bready} !== 4'b0000) begin fails++; $display("FAIL rst_ctrl got %b exp 0000", {S_AXIS_tready, SM_reading, SM_writing, M_AXI_bready}); end
    checks++; if (dut.outstanding !== 4'd0) begin fails++; $display("FAIL rst_outstanding got %0d exp 0", dut.outstanding); end
    SYS_aresetn = 1'b1; M_AXI_bvalid = 1'b0; S_AXIS_tvalid = 1'b0;
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1;
    tick();
    #1;
    checks++; if (M_AXI_awvalid !== 1'b0) begin fails++; $display("FAIL rst_abandoned got %b exp 0", M_AXI_awvalid); end
    tick();
  endtask

  task automatic test_error_count();
    logic [1:0] resp [4];
    int wr;
    logic [15:0] exp_cnt;
    resp[0] = 2'b00; resp[1] = 2'b10; resp[2] = 2'b11; resp[3] = 2'b00;
`ifdef S2MM_ERROR_COUNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    wr = 0;
    M_AXI_awready = 1'b1; M_AXI_wready = 1'b1; SM_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S_AXIS_tdata = 32'hE000_0000 + 32'(i); SM_write_buffer = 32'h5000_0000 + 32'(i * 4);
      S_AXIS_tvalid = 1'b1;
      tick();
      S_AXIS_tvalid = 1'b0;
      tick();
      M_AXI_bvalid = 1'b1; M_AXI_bresp = resp[i];
      #1;
      if (SM_writing === 1'b1) wr++;
      tick();
      M_AXI_bvalid = 1'b0; M_AXI_bresp = 2'b00;
    end
    tick();
    #1;
    checks++; if (wr !== 4) begin fails++; $display("FAIL err_writing got %0d exp 4", wr); end
    checks++; if (SM_error_count !== exp_cnt) begin fails++; $display("FAIL err_count got %0d exp %0d", SM_error_count, exp_cnt); end
    tick();
  endtask

  initial begin
    SYS_aresetn = 1'b0; SM_enable = 1'b0; S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0;
    SM_write_buffer = '0; M_AXI_awready = 1'b0; M_AXI_wready = 1'b0;
    M_AXI_bresp = 2'b00; M_AXI_bvalid = 1'b0;
    test_reset();
    test_single();
    test_skewed();
    test_back_to_back();
    test_enable_reset();
    test_error_count();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
